// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART ACK receiver: FSM state encoding,
// default acknowledge byte and bit-period calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_START,
    ST_RX_DATA,
    ST_RX_STOP,
    ST_ACK_GAP,
    ST_ACK_START,
    ST_ACK_DATA,
    ST_ACK_STOP
  } uart_rx_state_t;

  localparam logic [7:0] UART_ACK_DEFAULT = 8'b11001100;

  function automatic int baud_count(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the receive and acknowledge phases. Counts
// 0..BAUD_COUNT-1 and reloads on terminal count or on an explicit clear.
module uart_bit_timer #(
  parameter int BAUD_COUNT = 217,
  parameter int CNT_W      = $clog2(BAUD_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_en,
  output logic [CNT_W-1:0] count,
  output logic             tc,
  output logic             half
);

  logic [CNT_W-1:0] count_q, count_d;

  assign tc    = (count_q == CNT_W'(BAUD_COUNT - 1));
  assign half  = (count_q == CNT_W'(BAUD_COUNT / 2 - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en) begin
      count_d = tc ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_ack_receiver.sv
// Receives one 8N1 UART frame, presents the byte to the host and answers each
// good frame with the acknowledge byte on tx.
module uart_ack_receiver
  import uart_pkg::*;
#(
  parameter int                    CLK_FREQ       = 50_000_000,
  parameter int                    UART_BAUD_RATE = 230400,
  parameter int                    UART_WIDTH     = 8,
  parameter logic [UART_WIDTH-1:0] UART_ACK       = UART_ACK_DEFAULT,
  parameter int                    ACK_GAP        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rx,
  output logic                  tx,
  output logic [UART_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int BAUD_COUNT = baud_count(CLK_FREQ, UART_BAUD_RATE);
  localparam int CNT_W      = $clog2(BAUD_COUNT);
  localparam int IDX_W      = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;

  uart_rx_state_t        state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [UART_WIDTH-1:0] shift_q, shift_d;
  logic [UART_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_error_q, frame_error_d;
  logic                  err_wait_q, err_wait_d;
  logic                  tx_q, tx_d;
  logic                  rx_meta_q, rx_sync_q;

  logic                  tmr_clear, tmr_en, tmr_tc, tmr_half;
  logic [CNT_W-1:0]      tmr_count;

  uart_bit_timer #(
    .BAUD_COUNT (BAUD_COUNT),
    .CNT_W      (CNT_W)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .count_en (tmr_en),
    .count    (tmr_count),
    .tc       (tmr_tc),
    .half     (tmr_half)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    err_wait_d    = err_wait_q;
    tmr_en        = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        tmr_en = 1'b0;
        if (enable && !rx_sync_q) state_d = ST_RX_START;
      end
      ST_RX_START: begin
        if (tmr_half) begin
          state_d = rx_sync_q ? ST_IDLE : ST_RX_DATA;
          idx_d   = '0;
        end
      end
      ST_RX_DATA: begin
        if (tmr_tc) begin
          shift_d = {rx_sync_q, shift_q[UART_WIDTH-1:1]};
          if (idx_q == IDX_W'(UART_WIDTH - 1)) begin
            state_d = ST_RX_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_RX_STOP: begin
        // After a bad stop bit, park here until the line returns to idle.
        if (err_wait_q) begin
          tmr_en = 1'b0;
          if (rx_sync_q) begin
            err_wait_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end else if (tmr_tc) begin
          if (rx_sync_q) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            state_d      = ST_ACK_GAP;
          end else begin
            frame_error_d = 1'b1;
            err_wait_d    = 1'b1;
          end
        end
      end
      ST_ACK_GAP: begin
        if (tmr_count == CNT_W'(ACK_GAP)) state_d = ST_ACK_START;
      end
      ST_ACK_START: begin
        if (tmr_tc) begin
          state_d = ST_ACK_DATA;
          idx_d   = '0;
        end
      end
      ST_ACK_DATA: begin
        if (tmr_tc) begin
          if (idx_q == IDX_W'(UART_WIDTH - 1)) begin
            state_d = ST_ACK_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_ACK_STOP: begin
        if (tmr_tc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tmr_clear = (state_d != state_q);

  // tx is registered from the next state so the line never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_ACK_START: tx_d = 1'b0;
      ST_ACK_DATA:  tx_d = UART_ACK[idx_d];
      default:      tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      err_wait_q    <= 1'b0;
      tx_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      err_wait_q    <= err_wait_d;
      tx_q          <= tx_d;
    end
  end

  assign tx          = tx_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_ack_receiver.sv
// Directed bench for uart_ack_receiver: drives UART frames on rx, decodes the
// acknowledge on tx and checks counts, values and latencies.
module tb_uart_ack_receiver;

  localparam int BAUD = 217;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       rx = 1'b1;
  logic       tx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  uart_ack_receiver dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rx          (rx),
    .tx          (tx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int         cyc = 0;
  int         dv_cnt = 0, fe_cnt = 0, both_cnt = 0, tx_low_cnt = 0, busy_cnt = 0;
  int         dv_cyc = 0;
  logic [7:0] dv_last = 8'h00;
  int         ack_cnt = 0;
  int         start_cyc = 0;
  logic [7:0] ack_last = 8'h00;
  logic [7:0] dec;
  int         t_fall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      dv_cnt  <= dv_cnt + 1;
      dv_last <= data_out;
      dv_cyc  <= cyc;
    end
    if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
    if (data_valid === 1'b1 && frame_error === 1'b1) both_cnt <= both_cnt + 1;
    if (tx === 1'b0) tx_low_cnt <= tx_low_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  // Independent UART decoder for the acknowledge line.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        start_cyc = cyc;
        repeat (BAUD / 2) @(negedge clk);
        if (tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge clk);
            dec[i] = tx;
          end
          repeat (BAUD) @(negedge clk);
          if (tx === 1'b1) begin
            ack_cnt  = ack_cnt + 1;
            ack_last = dec;
          end
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, observed %0d cycles required < 90000", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic drop_en);
    @(negedge clk);
    rx     = 1'b0;
    t_fall = cyc;
    repeat (BAUD) @(negedge clk);
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  int dv0, ack0, fe0, txl0, busy0, n;

  initial begin
    // Reset values
    repeat (5) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_data_out", {24'd0, data_out}, 32'h00);
    chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_frame_error", {31'd0, frame_error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: good frame 0x02 and its ACK
    dv0 = dv_cnt; ack0 = ack_cnt;
    send_byte(8'h02, 1'b1, 1'b0);
    wait_idle("t1_idle");
    chk("t1_dv_count", dv_cnt - dv0, 1);
    chk("t1_data", {24'd0, dv_last}, 32'h02);
    chk("t1_dv_latency", dv_cyc - t_fall, 2 + BAUD / 2 + 9 * BAUD + 1);
    chk("t1_ack_count", ack_cnt - ack0, 1);
    chk("t1_ack_byte", {24'd0, ack_last}, 32'hCC);
    chk("t1_ack_latency", start_cyc - dv_cyc, 17);

    // 2: 40-clock glitch on rx
    dv0 = dv_cnt; fe0 = fe_cnt; txl0 = tx_low_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 110) begin
      @(negedge clk);
      n++;
    end
    chk("t2_busy_drop", {31'd0, busy}, 32'd0);
    repeat (300) @(negedge clk);
    chk("t2_no_dv", dv_cnt - dv0, 0);
    chk("t2_no_fe", fe_cnt - fe0, 0);
    chk("t2_tx_high", tx_low_cnt - txl0, 0);

    // 3: bad stop bit, then a good frame
    dv0 = dv_cnt; fe0 = fe_cnt; txl0 = tx_low_cnt;
    send_byte(8'hA5, 1'b0, 1'b0);
    wait_idle("t3_idle_err");
    repeat (50) @(negedge clk);
    chk("t3_fe_count", fe_cnt - fe0, 1);
    chk("t3_no_dv", dv_cnt - dv0, 0);
    chk("t3_data_held", {24'd0, data_out}, 32'h02);
    chk("t3_no_ack", tx_low_cnt - txl0, 0);
    ack0 = ack_cnt;
    send_byte(8'h3C, 1'b1, 1'b0);
    wait_idle("t3_idle_good");
    chk("t3_data", {24'd0, dv_last}, 32'h3C);
    chk("t3_ack_count", ack_cnt - ack0, 1);
    chk("t3_ack_byte", {24'd0, ack_last}, 32'hCC);

    // 4: enable low ignores a frame; dropping enable mid-frame does not
    enable = 1'b0;
    dv0 = dv_cnt; busy0 = busy_cnt; txl0 = tx_low_cnt;
    send_byte(8'h55, 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    chk("t4_busy_idle", busy_cnt - busy0, 0);
    chk("t4_no_dv", dv_cnt - dv0, 0);
    chk("t4_no_ack", tx_low_cnt - txl0, 0);
    enable = 1'b1;
    repeat (10) @(negedge clk);
    ack0 = ack_cnt;
    send_byte(8'h55, 1'b1, 1'b1);
    wait_idle("t4_idle");
    chk("t4_dv_count", dv_cnt - dv0, 1);
    chk("t4_data", {24'd0, dv_last}, 32'h55);
    chk("t4_ack_count", ack_cnt - ack0, 1);
    enable = 1'b1;
    repeat (10) @(negedge clk);

    // 5: reset during ACK data bit 3
    send_byte(8'h69, 1'b1, 1'b0);
    n = 0;
    while (start_cyc <= t_fall && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("t5_ack_started", {31'd0, start_cyc > t_fall}, 32'd1);
    while (cyc < start_cyc + 4 * BAUD + 100) @(negedge clk);
    chk("t5_busy_before", {31'd0, busy}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_tx", {31'd0, tx}, 32'd1);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_data_out", {24'd0, data_out}, 32'h00);
    chk("t5_rst_dv", {31'd0, data_valid}, 32'd0);
    chk("t5_rst_fe", {31'd0, frame_error}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8 * BAUD) @(negedge clk);
    dv0 = dv_cnt; ack0 = ack_cnt;
    send_byte(8'hFF, 1'b1, 1'b0);
    wait_idle("t5_idle");
    chk("t5_dv_count", dv_cnt - dv0, 1);
    chk("t5_data", {24'd0, dv_last}, 32'hFF);
    chk("t5_ack_count", ack_cnt - ack0, 1);
    chk("t5_ack_byte", {24'd0, ack_last}, 32'hCC);

    // 6: back-to-back frames
    dv0 = dv_cnt; ack0 = ack_cnt;
    send_byte(8'h01, 1'b1, 1'b0);
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("t6_first_data", {24'd0, dv_last}, 32'h01);
    send_byte(8'h80, 1'b1, 1'b0);
    wait_idle("t6_idle");
    chk("t6_dv_count", dv_cnt - dv0, 2);
    chk("t6_second_data", {24'd0, dv_last}, 32'h80);
    chk("t6_ack_count", ack_cnt - ack0, 2);
    chk("t6_ack_byte", {24'd0, ack_last}, 32'hCC);

    chk("dv_fe_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
